// File: rtl/lectura_rtc_if.sv
// rtl/lectura_rtc_if.sv - multiplexed address/data bus between the read sequencer and the RTC chip
interface lectura_rtc_if;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic       cs_n;
   logic       ad_n;
   logic       wr_n;
   logic       rd_n;

   modport master (
      input  ad_in,
      output ad_out,
      output ad_oe,
      output cs_n,
      output ad_n,
      output wr_n,
      output rd_n
   );

   modport slave (
      output ad_in,
      input  ad_out,
      input  ad_oe,
      input  cs_n,
      input  ad_n,
      input  wr_n,
      input  rd_n
   );
endinterface

// File: rtl/lectura_rtc.sv
// rtl/lectura_rtc.sv - RTC read-burst sequencer with register bank; optional BCD check via LECTURA_RTC_BCD_CHECK_EN
module lectura_rtc #(
   parameter int         T_PULSE  = 4,
   parameter int         T_GAP    = 2,
   parameter int         N_REGS   = 9,
   parameter logic [7:0] REG_BASE = 8'h21
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   lectura_rtc_if.master bus,
   output logic          busy,
   output logic          done,
   input  logic [3:0]    rd_addr,
   output logic [7:0]    rd_data,
   output logic          bcd_err
);
   // A zero-length strobe or gap would collapse the bus protocol, so it is stretched to one cycle.
   localparam int          TP       = (T_PULSE < 1) ? 1 : T_PULSE;
   localparam int          TG       = (T_GAP < 1) ? 1 : T_GAP;
   localparam logic [15:0] TP_LOAD  = 16'(TP - 1);
   localparam logic [15:0] TG_LOAD  = 16'(TG - 1);
   localparam logic [3:0]  LAST_IDX = 4'(N_REGS - 1);
   localparam logic [4:0]  N_REGS_W = 5'(N_REGS);

   typedef enum logic [2:0] {
      IDLE,
      ADDR_STB,
      ADDR_GAP,
      DATA_STB,
      DATA_GAP,
      DONE
   } state_t;

   state_t      state;
   logic [15:0] phase_cnt;
   logic [3:0]  idx;
   logic [3:0]  idx_next;
   logic [7:0]  bank [16];
   logic [7:0]  cap_byte;

   assign idx_next = idx + 4'd1;

`ifdef LECTURA_RTC_BCD_CHECK_EN
   logic cap_bad;

   // Non-BCD bytes are replaced by zero so the display never shows a garbage digit.
   assign cap_bad  = (bus.ad_in[7:4] > 4'd9) || (bus.ad_in[3:0] > 4'd9);
   assign cap_byte = cap_bad ? 8'h00 : bus.ad_in;
`else
   assign cap_byte = bus.ad_in;
   assign bcd_err  = 1'b0;
`endif

   // Burst sequencer: phase counter reloads on every state entry, bus outputs are registered with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         phase_cnt  <= 16'd0;
         idx        <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bus.cs_n   <= 1'b1;
         bus.ad_n   <= 1'b1;
         bus.wr_n   <= 1'b1;
         bus.rd_n   <= 1'b1;
         bus.ad_oe  <= 1'b0;
         bus.ad_out <= 8'h00;
         for (int i = 0; i < 16; i++) begin
            bank[i] <= 8'h00;
         end
`ifdef LECTURA_RTC_BCD_CHECK_EN
         bcd_err    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= ADDR_STB;
                  phase_cnt  <= TP_LOAD;
                  idx        <= 4'd0;
                  busy       <= 1'b1;
                  bus.cs_n   <= 1'b0;
                  bus.ad_n   <= 1'b0;
                  bus.wr_n   <= 1'b0;
                  bus.ad_oe  <= 1'b1;
                  bus.ad_out <= REG_BASE;
`ifdef LECTURA_RTC_BCD_CHECK_EN
                  bcd_err    <= 1'b0;
`endif
               end
            end
            ADDR_STB: begin
               if (phase_cnt != 16'd0) begin
                  phase_cnt <= phase_cnt - 16'd1;
               end else begin
                  state      <= ADDR_GAP;
                  phase_cnt  <= TG_LOAD;
                  bus.cs_n   <= 1'b1;
                  bus.ad_n   <= 1'b1;
                  bus.wr_n   <= 1'b1;
                  bus.ad_oe  <= 1'b0;
                  bus.ad_out <= 8'h00;
               end
            end
            ADDR_GAP: begin
               if (phase_cnt != 16'd0) begin
                  phase_cnt <= phase_cnt - 16'd1;
               end else begin
                  state     <= DATA_STB;
                  phase_cnt <= TP_LOAD;
                  bus.cs_n  <= 1'b0;
                  bus.ad_n  <= 1'b1;
                  bus.rd_n  <= 1'b0;
               end
            end
            DATA_STB: begin
               if (phase_cnt != 16'd0) begin
                  phase_cnt <= phase_cnt - 16'd1;
               end else begin
                  // Sample the RTC on the edge that closes the read strobe.
                  bank[idx] <= cap_byte;
`ifdef LECTURA_RTC_BCD_CHECK_EN
                  if (cap_bad) begin
                     bcd_err <= 1'b1;
                  end
`endif
                  state     <= DATA_GAP;
                  phase_cnt <= TG_LOAD;
                  bus.cs_n  <= 1'b1;
                  bus.rd_n  <= 1'b1;
               end
            end
            DATA_GAP: begin
               if (phase_cnt != 16'd0) begin
                  phase_cnt <= phase_cnt - 16'd1;
               end else if (idx == LAST_IDX) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state      <= ADDR_STB;
                  phase_cnt  <= TP_LOAD;
                  idx        <= idx_next;
                  bus.cs_n   <= 1'b0;
                  bus.ad_n   <= 1'b0;
                  bus.wr_n   <= 1'b0;
                  bus.ad_oe  <= 1'b1;
                  bus.ad_out <= REG_BASE + {4'b0000, idx_next};
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Bank read port; indexes past the burst length read as zero.
   always_comb begin
      rd_data = 8'h00;
      if ({1'b0, rd_addr} < N_REGS_W) begin
         rd_data = bank[rd_addr];
      end
   end
endmodule

// File: tb/tb_lectura_rtc.sv
// tb/tb_lectura_rtc.sv - directed bench for lectura_rtc with an RTC bus model (honours LECTURA_RTC_BCD_CHECK_EN)
module tb_lectura_rtc;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
   logic [3:0] rd_addr = 4'd0;
   logic [7:0] rd_data;
   logic       bcd_err;

   lectura_rtc_if bus ();

   lectura_rtc dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .bcd_err (bcd_err)
   );

   always #5 clk = ~clk;

   // RTC model: latches the address during the write strobe, returns 8'h10+i for address 8'h21+i.
   logic [7:0] rtc_addr;
   logic       bad_mode = 1'b0;

   always @(posedge clk) begin
      if (!bus.cs_n && !bus.ad_n && !bus.wr_n) rtc_addr <= bus.ad_out;
   end

   always_comb begin
      if (!bus.rd_n) begin
         if (bad_mode && rtc_addr == 8'h23) bus.ad_in = 8'h3A;
         else                              bus.ad_in = 8'h10 + (rtc_addr - 8'h21);
      end else begin
         bus.ad_in = 8'hFF;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle bus monitor: protocol violations, address sequence, done pulses.
   int         viol = 0;
   int         done_total = 0;
   logic [7:0] addr_q[$];
   logic       prev_wr_n = 1'b1;

   always @(negedge clk) begin
      if (bus.ad_oe === 1'b1 && bus.rd_n === 1'b0) viol++;
      if (bus.wr_n === 1'b0 && bus.rd_n === 1'b0) viol++;
      if (bus.wr_n === 1'b0 && prev_wr_n === 1'b1) addr_q.push_back(bus.ad_out);
      if (done === 1'b1) done_total++;
      prev_wr_n = bus.wr_n;
   end

   typedef struct {
      logic [3:0] addr;
      logic [7:0] exp;
   } vec_t;

   vec_t tab[16];

   int         b_done_edge, b_done_cnt, b_busy_fall, b_wr_low;
   logic       b_first_busy, b_first_wr, b_bcd1, b_bcd34, b_bcd35;
   logic [7:0] b_first_adout;

   // Issues one start pulse, optionally a second one sampled at edge extra_at+1, and follows the burst.
   task automatic run_burst(input int extra_at);
      int n;
      bit wr_phase;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 1;
      wr_phase = 1'b1;
      b_done_edge = 0; b_done_cnt = 0; b_busy_fall = 0; b_wr_low = 0;
      b_first_busy = busy; b_first_wr = bus.wr_n; b_first_adout = bus.ad_out;
      b_bcd1 = bcd_err; b_bcd34 = 1'bx; b_bcd35 = 1'bx;
      while (n < 300 && b_busy_fall == 0) begin
         if (wr_phase && bus.wr_n == 1'b0) b_wr_low++;
         else if (b_wr_low > 0)             wr_phase = 1'b0;
         if (done) begin
            b_done_cnt++;
            if (b_done_edge == 0) b_done_edge = n;
         end
         if (!busy && b_done_edge != 0) b_busy_fall = n;
         if (n == 34) b_bcd34 = bcd_err;
         if (n == 35) b_bcd35 = bcd_err;
         start = (n == extra_at);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      if (b_busy_fall == 0) chk("burst_timeout", 32'(n), 32'd0);
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < 16; i++) begin
         rd_addr = tab[i].addr;
         #1;
         chk($sformatf("%s_rd_data[%0d]", tag, i), 32'(rd_data), 32'(tab[i].exp));
      end
   endtask

   task automatic check_addr_seq(input string tag);
      chk({tag, "_addr_count"}, 32'(addr_q.size()), 32'd9);
      for (int i = 0; i < 9 && i < addr_q.size(); i++) begin
         chk($sformatf("%s_addr[%0d]", tag, i), 32'(addr_q[i]), 32'(8'h21 + i));
      end
   endtask

   initial begin
      int nz;
      for (int i = 0; i < 16; i++) begin
         tab[i].addr = 4'(i);
         tab[i].exp  = (i < 9) ? 8'(8'h10 + i) : 8'h00;
      end

      // Reset state.
      #2 rst = 1'b0;
      #10;
      chk("rst_cs_n", bus.cs_n, 1'b1);
      chk("rst_ad_n", bus.ad_n, 1'b1);
      chk("rst_wr_n", bus.wr_n, 1'b1);
      chk("rst_rd_n", bus.rd_n, 1'b1);
      chk("rst_ad_oe", bus.ad_oe, 1'b0);
      chk("rst_ad_out", bus.ad_out, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_bcd_err", bcd_err, 1'b0);
      rd_addr = 4'd0; #1;
      chk("rst_rd_data0", rd_data, 8'h00);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);

      // Burst 1: basic timing and captured data.
      addr_q.delete(); done_total = 0;
      run_burst(-1);
      chk("b1_busy_rise", b_first_busy, 1'b1);
      chk("b1_first_wr_n", b_first_wr, 1'b0);
      chk("b1_first_ad_out", b_first_adout, 8'h21);
      chk("b1_wr_low_cycles", 32'(b_wr_low), 32'd4);
      chk("b1_done_edge", 32'(b_done_edge), 32'd109);
      chk("b1_busy_fall", 32'(b_busy_fall), 32'd110);
      check_addr_seq("b1");
      check_bank("b1");

      // Burst 2: a start during the burst is ignored, not queued.
      addr_q.delete(); done_total = 0;
      run_burst(30);
      chk("b2_done_edge", 32'(b_done_edge), 32'd109);
      repeat (40) @(posedge clk);
      #1;
      chk("b2_done_total", 32'(done_total), 32'd1);
      chk("b2_idle_after", busy, 1'b0);
      check_addr_seq("b2");

      // Asynchronous reset in DATA_STB of index 4.
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (55) @(posedge clk);
      #1;
      chk("mid_rd_n_low", bus.rd_n, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_rd_n", bus.rd_n, 1'b1);
      chk("mid_rst_cs_n", bus.cs_n, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      nz = 0;
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         if (rd_data != 8'h00) nz++;
      end
      chk("mid_rst_bank_clear", 32'(nz), 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);
      addr_q.delete(); done_total = 0;
      run_burst(-1);
      chk("b3_done_edge", 32'(b_done_edge), 32'd109);
      chk("b3_done_total", 32'(done_total), 32'd1);
      check_bank("b3");

      // Non-BCD byte at index 2.
      bad_mode = 1'b1;
      run_burst(-1);
      bad_mode = 1'b0;
      rd_addr = 4'd2; #1;
`ifdef LECTURA_RTC_BCD_CHECK_EN
      chk("bcd_err_before_capture", b_bcd34, 1'b0);
      chk("bcd_err_after_capture", b_bcd35, 1'b1);
      chk("bcd_bank2", rd_data, 8'h00);
      chk("bcd_err_held", bcd_err, 1'b1);
`else
      chk("bcd_err_before_capture", b_bcd34, 1'b0);
      chk("bcd_err_after_capture", b_bcd35, 1'b0);
      chk("bcd_bank2", rd_data, 8'h3A);
      chk("bcd_err_held", bcd_err, 1'b0);
`endif
      rd_addr = 4'd3; #1;
      chk("bcd_bank3", rd_data, 8'h13);

      // Next start clears the sticky flag.
      run_burst(-1);
      chk("bcd_err_cleared", b_bcd1, 1'b0);
      chk("bcd_err_end", bcd_err, 1'b0);
      rd_addr = 4'd2; #1;
      chk("bank2_restored", rd_data, 8'h12);

      chk("protocol_violations", 32'(viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
